// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and the MEM stage.
// Optional per-access wait timeout with sticky busErr, enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int IF_MAX_SKIP    = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ifReq,
   input  logic [ADDR_W-1:0] ifAddr,
   output logic [DATA_W-1:0] ifRdata,
   output logic              ifAck,
   input  logic              memReq,
   input  logic              memWe,
   input  logic [ADDR_W-1:0] memAddr,
   input  logic [DATA_W-1:0] memWdata,
   output logic [DATA_W-1:0] memRdata,
   output logic              memAck,
   output logic              stall,
   output logic              ramReq,
   output logic              ramWe,
   output logic [ADDR_W-1:0] ramAddr,
   output logic [DATA_W-1:0] ramWdata,
   input  logic [DATA_W-1:0] ramRdata,
   input  logic              ramReady,
   output logic              busErr
);

   // state    | meaning
   // IDLE     | arbitrate between ifReq and memReq
   // BUSY_IF  | fetch outstanding on the memory port
   // BUSY_MEM | load/store outstanding on the memory port
   // RESP     | one-cycle ack to the winner; requests ignored
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;

   localparam logic [3:0] SKIP_LIM = 4'(IF_MAX_SKIP);

   if (IF_MAX_SKIP < 1 || IF_MAX_SKIP > 15 || TIMEOUT_CYCLES < 1) begin : g_param_chk
      $error("mem_port_arbiter: IF_MAX_SKIP must be 1..15 and TIMEOUT_CYCLES >= 1");
   end

   state_t     state;
   logic [3:0] skip_cnt;
   logic       timeout_hit;
   logic       busy;

   assign busy  = (state == BUSY_IF) || (state == BUSY_MEM);
   assign stall = (ifReq & ~ifAck) | (memReq & ~memAck);

`ifdef ARB_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WAIT_W-1:0] wait_tmr;
   logic              bus_err_q;

   // down-counter loaded on grant; terminal count with no ready aborts the access
   assign timeout_hit = busy && !ramReady && (wait_tmr == '0);
   assign busErr      = bus_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_tmr  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         if (state == IDLE)
            wait_tmr <= WAIT_W'(TIMEOUT_CYCLES - 1);
         else if (busy && !ramReady && wait_tmr != '0)
            wait_tmr <= wait_tmr - 1'b1;
         if (timeout_hit)
            bus_err_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign busErr      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         skip_cnt <= '0;
         ifRdata  <= '0;
         memRdata <= '0;
         ifAck    <= 1'b0;
         memAck   <= 1'b0;
         ramReq   <= 1'b0;
         ramWe    <= 1'b0;
         ramAddr  <= '0;
         ramWdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               // MEM is older in the pipeline, but IF gets through after SKIP_LIM losses
               if (memReq && (skip_cnt < SKIP_LIM || !ifReq)) begin
                  state    <= BUSY_MEM;
                  ramReq   <= 1'b1;
                  ramWe    <= memWe;
                  ramAddr  <= memAddr;
                  ramWdata <= memWdata;
                  if (ifReq)
                     skip_cnt <= skip_cnt + 4'd1;
               end else if (ifReq) begin
                  state    <= BUSY_IF;
                  ramReq   <= 1'b1;
                  ramWe    <= 1'b0;
                  ramAddr  <= ifAddr;
                  ramWdata <= '0;
                  skip_cnt <= '0;
               end
            end
            BUSY_IF: begin
               if (ramReady || timeout_hit) begin
                  state   <= RESP;
                  ramReq  <= 1'b0;
                  ifAck   <= 1'b1;
                  ifRdata <= ramReady ? ramRdata : '0;
               end
            end
            BUSY_MEM: begin
               if (ramReady || timeout_hit) begin
                  state  <= RESP;
                  ramReq <= 1'b0;
                  memAck <= 1'b1;
                  if (!ramReady)
                     memRdata <= '0;
                  else if (!ramWe)
                     memRdata <= ramRdata;
               end
            end
            RESP: begin
               state  <= IDLE;
               ifAck  <= 1'b0;
               memAck <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; outputs sampled on the falling edge.
// Timeout checks are compiled in when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic          clk;
   logic          reset;
   logic          ifReq;
   logic [AW-1:0] ifAddr;
   logic [DW-1:0] ifRdata;
   logic          ifAck;
   logic          memReq;
   logic          memWe;
   logic [AW-1:0] memAddr;
   logic [DW-1:0] memWdata;
   logic [DW-1:0] memRdata;
   logic          memAck;
   logic          stall;
   logic          ramReq;
   logic          ramWe;
   logic [AW-1:0] ramAddr;
   logic [DW-1:0] ramWdata;
   logic [DW-1:0] ramRdata;
   logic          ramReady;
   logic          busErr;

   int n_cmp = 0;
   int n_err = 0;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .IF_MAX_SKIP(4), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifAck(ifAck),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memRdata(memRdata), .memAck(memAck), .stall(stall),
      .ramReq(ramReq), .ramWe(ramWe), .ramAddr(ramAddr), .ramWdata(ramWdata),
      .ramRdata(ramRdata), .ramReady(ramReady), .busErr(busErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nclk();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      ifReq    = 1'b0;
      ifAddr   = '0;
      memReq   = 1'b0;
      memWe    = 1'b0;
      memAddr  = '0;
      memWdata = '0;
      ramRdata = '0;
      ramReady = 1'b0;
      repeat (2) nclk();
      reset = 1'b0;
   endtask

   // single fetch with ready in the first busy cycle; returns at the cycle after the ack
   task automatic fetch(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
      ifReq = 1'b1; ifAddr = a; ramReady = 1'b1; ramRdata = d;
      nclk();
      chk({tag, "_ramreq"}, ramReq, 1'b1);
      nclk();
      chk({tag, "_ack"}, ifAck, 1'b1);
      chk({tag, "_rdata"}, ifRdata, d);
      ifReq = 1'b0; ramReady = 1'b0;
      nclk();
   endtask

   initial begin : main
      int  grants;
      int  t;
      logic got_mem;

      do_reset();

      // reset state
      chk("rst_ramreq", ramReq, 1'b0);
      chk("rst_ramwe", ramWe, 1'b0);
      chk("rst_ramaddr", ramAddr, 32'h0);
      chk("rst_acks", {ifAck, memAck}, 2'b00);
      chk("rst_rdata", {ifRdata, memRdata}, 64'h0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_buserr", busErr, 1'b0);

      // single fetch, cycle-exact
      ifReq = 1'b1; ifAddr = 32'h100; ramReady = 1'b1; ramRdata = 32'h0050_0093;
      #1 chk("f_stall_c0", stall, 1'b1);
      chk("f_ramreq_c0", ramReq, 1'b0);
      nclk();
      chk("f_ramreq_c1", ramReq, 1'b1);
      chk("f_ramaddr_c1", ramAddr, 32'h100);
      chk("f_ramwe_c1", ramWe, 1'b0);
      chk("f_ack_c1", ifAck, 1'b0);
      chk("f_stall_c1", stall, 1'b1);
      nclk();
      chk("f_ack_c2", ifAck, 1'b1);
      chk("f_rdata_c2", ifRdata, 32'h0050_0093);
      chk("f_stall_c2", stall, 1'b0);
      chk("f_ramreq_c2", ramReq, 1'b0);
      ifReq = 1'b0; ramReady = 1'b0; ramRdata = 32'h1234_5678;
      nclk();
      chk("f_ack_c3", ifAck, 1'b0);
      chk("f_hold_c3", ifRdata, 32'h0050_0093);

      // store with three wait states
      memReq = 1'b1; memWe = 1'b1; memAddr = 32'h20; memWdata = 32'hDEAD_BEEF;
      for (int k = 1; k <= 4; k++) begin
         nclk();
         chk($sformatf("st_ramreq_%0d", k), ramReq, 1'b1);
         chk($sformatf("st_ramwe_%0d", k), ramWe, 1'b1);
         chk($sformatf("st_wdata_%0d", k), ramWdata, 32'hDEAD_BEEF);
         chk($sformatf("st_addr_%0d", k), ramAddr, 32'h20);
         chk($sformatf("st_noack_%0d", k), memAck, 1'b0);
         if (k == 4) ramReady = 1'b1;
      end
      nclk();
      chk("st_ack", memAck, 1'b1);
      chk("st_rdata_kept", memRdata, 32'h0);
      chk("st_ramreq_off", ramReq, 1'b0);
      memReq = 1'b0; ramReady = 1'b0;
      nclk();
      chk("st_single_ack", memAck, 1'b0);

      // contention fairness: expect M,M,M,M,I repeating
      do_reset();
      ifReq = 1'b1; ifAddr = 32'h100;
      memReq = 1'b1; memWe = 1'b0; memAddr = 32'h200;
      ramReady = 1'b1; ramRdata = 32'hCAFE_0000;
      grants = 0;
      t = 0;
      while (grants < 10 && t < 60) begin
         nclk();
         t++;
         if (ramReq) begin
            got_mem = (ramAddr == 32'h200);
            chk($sformatf("fair_grant_%0d", grants), got_mem, (grants % 5) != 4);
            grants++;
         end
      end
      chk("fair_grant_count", grants, 10);
      ifReq = 1'b0; memReq = 1'b0;
      repeat (3) nclk();

      // reset mid-access
      do_reset();
      memReq = 1'b1; memWe = 1'b0; memAddr = 32'h40; ramRdata = 32'h5555_AAAA;
      repeat (2) nclk();
      chk("rm_busy", ramReq, 1'b1);
      reset = 1'b1;
      nclk();
      chk("rm_ramreq_off", ramReq, 1'b0);
      reset = 1'b0; memReq = 1'b0; ramReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
         nclk();
         chk($sformatf("rm_noack_%0d", k), memAck, 1'b0);
      end
      chk("rm_ramreq", ramReq, 1'b0);
      chk("rm_addr_wdata", {ramAddr, ramWdata}, 64'h0);
      chk("rm_ramwe", ramWe, 1'b0);
      chk("rm_rdata", {ifRdata, memRdata}, 64'h0);
      fetch("rm_idle_fetch", 32'h300, 32'h0000_0013);

      // back-to-back loads
      do_reset();
      memReq = 1'b1; memWe = 1'b0; memAddr = 32'h0; ramReady = 1'b1; ramRdata = 32'h1111_0000;
      nclk();
      chk("bb_ramreq_a", ramReq, 1'b1);
      chk("bb_addr_a", ramAddr, 32'h0);
      nclk();
      chk("bb_ack_a", memAck, 1'b1);
      chk("bb_rdata_a", memRdata, 32'h1111_0000);
      memAddr = 32'h4; ramRdata = 32'h2222_0004;
      nclk();
      chk("bb_gap_ack", memAck, 1'b0);
      chk("bb_gap_ramreq", ramReq, 1'b0);
      nclk();
      chk("bb_ramreq_b", ramReq, 1'b1);
      chk("bb_addr_b", ramAddr, 32'h4);
      chk("bb_noack_b", memAck, 1'b0);
      nclk();
      chk("bb_ack_b", memAck, 1'b1);
      chk("bb_rdata_b", memRdata, 32'h2222_0004);
      memReq = 1'b0; ramReady = 1'b0;
      nclk();
      chk("bb_single_ack", memAck, 1'b0);
      chk("bb_hold_b", memRdata, 32'h2222_0004);

`ifdef ARB_TIMEOUT_EN
      // timeout: eight wait cycles, then an aborted fetch acked with zero data
      do_reset();
      fetch("to_pre", 32'h100, 32'h0050_0093);
      ifReq = 1'b1; ifAddr = 32'h104; ramReady = 1'b0; ramRdata = 32'hFFFF_FFFF;
      for (int k = 1; k <= 8; k++) begin
         nclk();
         chk($sformatf("to_wait_%0d", k), {ramReq, ifAck}, 2'b10);
      end
      nclk();
      chk("to_ack", ifAck, 1'b1);
      chk("to_rdata", ifRdata, 32'h0);
      chk("to_buserr", busErr, 1'b1);
      chk("to_ramreq_off", ramReq, 1'b0);
      ifReq = 1'b0;
      nclk();
      fetch("to_post", 32'h108, 32'h0000_0033);
      chk("to_sticky", busErr, 1'b1);
`else
      chk("no_to_buserr", busErr, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch stage (read-only) and the MEM stage (loads and stores driven by the decoded memRead/memWrite controls).
- Sequences each access over a variable-latency memory with a ready handshake.
- Drives the pipeline-wide stall while any access is outstanding.
- Sits between the IF/MEM stage logic and the memory model/wrapper.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
IF_MAX_SKIP, 4, consecutive arbitrations IF may lose while requesting before it is forced to win (range 1..15)
TIMEOUT_CYCLES, 255, wait-cycle limit per access; used only with the optional feature

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous reset, active-high
ifReq  input  1  fetch request, level, held until ifAck
ifAddr  input  ADDR_W  fetch address, stable while ifReq
ifRdata  output  DATA_W  fetched instruction, valid when ifAck
ifAck  output  1  one-cycle completion pulse to IF
memReq  input  1  data request (memRead|memWrite), level, held until memAck
memWe  input  1  1 = store, 0 = load; stable while memReq
memAddr  input  ADDR_W  data address
memWdata  input  DATA_W  store data
memRdata  output  DATA_W  load data, valid when memAck
memAck  output  1  one-cycle completion pulse to MEM
stall  output  1  pipeline freeze
ramReq  output  1  memory access strobe
ramWe  output  1  memory write enable
ramAddr  output  ADDR_W  memory address
ramWdata  output  DATA_W  memory write data
ramRdata  input  DATA_W  memory read data, valid with ramReady
ramReady  input  1  memory completes current access this cycle
busErr  output  1  sticky timeout error (optional feature)

Behaviour:
- Reset values: state IDLE; ifRdata, memRdata, ramAddr, ramWdata = 0; ifAck, memAck, ramReq, ramWe, busErr = 0; skip counter = 0. ramReq deasserts in the cycle after reset is sampled, even mid-access. Any later ramReady for an aborted access is ignored.
- States: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE arbitration:
  - If memReq and (skipCnt < IF_MAX_SKIP or !ifReq): go to BUSY_MEM. If ifReq was also asserted, skipCnt++.
  - Else if ifReq: go to BUSY_IF, skipCnt = 0.
  - Else stay in IDLE.
  - On grant, register ramAddr/ramWdata/ramWe from the winner. ramWe = 0 for IF.
- BUSY_x: ramReq = 1 and ramAddr/ramWe/ramWdata are held. When ramReady = 1, capture ramRdata into the winner's rdata register (load/fetch only; store leaves memRdata unchanged), drop ramReq, and go to RESP.
- RESP: pulse the winner's ack for exactly one cycle, then go to IDLE. Requests are not sampled in RESP, because the acked requester still shows req this cycle.
- Latency: request first seen in IDLE at cycle 0 -> ramReq in cycle 1 -> with ramReady in cycle 1, ack in cycle 2. Minimum spacing between grants is 3 cycles.
- stall = (ifReq & !ifAck) | (memReq & !memAck), combinational. It is low in the ack cycle so the pipeline advances.
- Simultaneous requests: MEM wins (older instruction) until IF has lost IF_MAX_SKIP times in a row; the next arbitration is then won by IF.
- ifRdata and memRdata hold their last captured value between acks.
- Inputs are not checked for changes while req is high; requesters must keep them stable.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to BUSY_x and increments each cycle without ramReady.
  - If it reaches TIMEOUT_CYCLES, the access is aborted: ramReq drops, the winner's rdata is set to 0, the FSM goes to RESP and acks normally, and busErr is set sticky until reset.
  - ramReady in the same cycle as the limit counts as success.
- Undefined: no counter; BUSY_x waits indefinitely; busErr is tied to 0.

Test Plan:
- Single fetch: ifReq=1, ifAddr=0x100, ramReady=1 with ramRdata=0x00500093 -> ramReq in cycle 1 with ramAddr=0x100, ramWe=0; ifAck=1 and ifRdata=0x00500093 in cycle 2; stall=1 in cycles 0-1, 0 in cycle 2.
- Store with 3 wait states: memReq=1, memWe=1, memAddr=0x20, memWdata=0xDEADBEEF, ramReady raised in the 4th BUSY cycle -> ramWe=1 and ramWdata=0xDEADBEEF held through all 4 cycles; a single memAck; memRdata unchanged.
- Contention fairness: ifReq and memReq held high continuously, with MEM re-requesting immediately after each ack, IF_MAX_SKIP=4 -> grant order MEM,MEM,MEM,MEM,IF, repeating.
- Reset mid-access: in BUSY_MEM, assert reset for 1 cycle, then raise ramReady -> ramReq=0 after reset; no memAck; state IDLE; all outputs at reset values.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): ifReq with ramReady stuck at 0 -> ifAck after 8 wait cycles with ifRdata=0; busErr=1 and stays 1 through later successful accesses.
- Back-to-back loads: memReq held with new memAddr 0x0, 0x4 after each ack -> each access is 3 cycles with ramReady=1 immediately; no duplicate acks; memRdata matches each ramRdata.
